// File: rtl/avr_dmem_arbiter_if.sv
// avr_dmem_arbiter_if: CPU, DMA and data-memory bus bundle for the data-memory arbiter.
interface avr_dmem_arbiter_if #(parameter int ADDR_W = 9);
  logic              cpu_req;
  logic              cpu_we;
  logic [15:0]       cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_stall;
  logic              dma_req;
  logic              dma_we;
  logic [15:0]       dma_addr;
  logic [7:0]        dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [7:0]        dma_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    output cpu_rdata, cpu_stall, dma_gnt, dma_rvalid, dma_rdata, mem_addr, mem_we, mem_wdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    input  cpu_rdata, cpu_stall, dma_gnt, dma_rvalid, dma_rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/avr_dmem_arbiter.sv
// avr_dmem_arbiter: shares single-port data memory between the CPU and a DMA master, CPU priority.
// Optional DMA starvation guard enabled by defining DMEM_ARB_FAIR_EN.
module avr_dmem_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  avr_dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_e;
  owner_e      own_q, own_d;
  logic        oor_q, oor_d;
  logic        cpu_gnt, dma_gnt, force_dma, g_we, g_oor;
  logic [15:0] g_addr;
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end
  always_comb begin
    cpu_gnt = bus.cpu_req & ~(bus.dma_req & force_dma);
    dma_gnt = bus.dma_req & ~cpu_gnt;
    g_addr  = cpu_gnt ? bus.cpu_addr : dma_gnt ? bus.dma_addr : 16'h0000;
    g_we    = cpu_gnt ? bus.cpu_we : dma_gnt & bus.dma_we;
    g_oor   = |g_addr[15:ADDR_W];
    own_d   = (cpu_gnt & ~bus.cpu_we) ? OWN_CPU : (dma_gnt & ~bus.dma_we) ? OWN_DMA : OWN_NONE;
    oor_d   = (own_d != OWN_NONE) & g_oor;
  end
  assign bus.mem_addr   = g_addr[ADDR_W-1:0];
  assign bus.mem_we     = g_we & ~g_oor;
  assign bus.mem_wdata  = cpu_gnt ? bus.cpu_wdata : dma_gnt ? bus.dma_wdata : 8'h00;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  // Out-of-range reads keep their owner so the DMA still sees a valid pulse, but data is zeroed.
  assign bus.cpu_rdata  = (own_q == OWN_CPU && !oor_q) ? bus.mem_rdata : 8'h00;
  assign bus.dma_rvalid = own_q == OWN_DMA;
  assign bus.dma_rdata  = (own_q == OWN_DMA && !oor_q) ? bus.mem_rdata : 8'h00;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      own_q <= OWN_NONE;
      oor_q <= 1'b0;
    end else begin
      own_q <= own_d;
      oor_q <= oor_d;
    end
  end
`ifdef DMEM_ARB_FAIR_EN
  logic [3:0] cnt_q, cnt_d;
  assign force_dma = cnt_q == 4'(STARVE_LIMIT);
  assign cnt_d     = (~bus.dma_req | dma_gnt) ? 4'd0 : force_dma ? cnt_q : cnt_q + 4'd1;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
  end
`else
  assign force_dma = 1'b0;
`endif
endmodule

// File: tb/tb_avr_dmem_arbiter.sv
// tb_avr_dmem_arbiter: directed self-checking bench with a registered 512-byte memory model.
module tb_avr_dmem_arbiter;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] mem [512];
  avr_dmem_arbiter_if #(.ADDR_W(9)) bus ();
  avr_dmem_arbiter #(.ADDR_W(9), .STARVE_LIMIT(4)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h77;
      bus.mem_rdata <= 8'h00;
    end else begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic cpu(input logic req, input logic we, input logic [15:0] addr, input logic [7:0] wd);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
  endtask
  task automatic dma(input logic req, input logic we, input logic [15:0] addr, input logic [7:0] wd);
    bus.dma_req = req; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wd;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_cpu_rdata"}, 16'(bus.cpu_rdata), 16'h00);
    chk({tag, "_cpu_stall"}, 16'(bus.cpu_stall), 16'h0);
    chk({tag, "_dma_gnt"}, 16'(bus.dma_gnt), 16'h0);
    chk({tag, "_dma_rvalid"}, 16'(bus.dma_rvalid), 16'h0);
    chk({tag, "_dma_rdata"}, 16'(bus.dma_rdata), 16'h00);
    chk({tag, "_mem_we"}, 16'(bus.mem_we), 16'h0);
    chk({tag, "_mem_addr"}, 16'(bus.mem_addr), 16'h000);
    chk({tag, "_mem_wdata"}, 16'(bus.mem_wdata), 16'h00);
  endtask
  initial begin
    cpu(0, 0, 16'h0, 8'h0);
    dma(0, 0, 16'h0, 8'h0);
    step();
    chk_idle("reset");
    step();
    rst_i = 1'b0;
    // CPU write then read with no DMA traffic
    cpu(1, 1, 16'h0010, 8'hA5);
    #1;
    chk("wr_stall", 16'(bus.cpu_stall), 16'h0);
    chk("wr_mem_we", 16'(bus.mem_we), 16'h1);
    chk("wr_mem_addr", 16'(bus.mem_addr), 16'h010);
    chk("wr_mem_wdata", 16'(bus.mem_wdata), 16'hA5);
    step();
    cpu(1, 0, 16'h0010, 8'h00);
    #1;
    chk("rd_stall", 16'(bus.cpu_stall), 16'h0);
    chk("rd_mem_we", 16'(bus.mem_we), 16'h0);
    step();
    cpu(0, 0, 16'h0, 8'h0);
    #1;
    chk("rd_cpu_rdata", 16'(bus.cpu_rdata), 16'hA5);
    chk("rd_no_rvalid", 16'(bus.dma_rvalid), 16'h0);
    // contention: CPU read wins, DMA write follows
    cpu(1, 0, 16'h0010, 8'h00);
    dma(1, 1, 16'h0020, 8'h5A);
    #1;
    chk("con_stall", 16'(bus.cpu_stall), 16'h0);
    chk("con_dma_gnt", 16'(bus.dma_gnt), 16'h0);
    chk("con_mem_addr", 16'(bus.mem_addr), 16'h010);
    step();
    cpu(0, 0, 16'h0, 8'h0);
    #1;
    chk("con2_dma_gnt", 16'(bus.dma_gnt), 16'h1);
    chk("con2_mem_we", 16'(bus.mem_we), 16'h1);
    chk("con2_mem_addr", 16'(bus.mem_addr), 16'h020);
    chk("con2_cpu_rdata", 16'(bus.cpu_rdata), 16'hA5);
    step();
    dma(1, 0, 16'h0020, 8'h00);
    #1;
    chk("drd_gnt", 16'(bus.dma_gnt), 16'h1);
    chk("drd_rvalid_early", 16'(bus.dma_rvalid), 16'h0);
    step();
    dma(0, 0, 16'h0, 8'h0);
    #1;
    chk("drd_rvalid", 16'(bus.dma_rvalid), 16'h1);
    chk("drd_rdata", 16'(bus.dma_rdata), 16'h5A);
    chk("drd_cpu_rdata", 16'(bus.cpu_rdata), 16'h00);
    step();
    chk("drd_rvalid_pulse", 16'(bus.dma_rvalid), 16'h0);
    // DMA alone, then CPU joins and takes priority
    dma(1, 0, 16'h0010, 8'h00);
    #1;
    chk("dalone_gnt", 16'(bus.dma_gnt), 16'h1);
    chk("dalone_stall", 16'(bus.cpu_stall), 16'h0);
    step();
    cpu(1, 0, 16'h0020, 8'h00);
    #1;
    chk("join_stall", 16'(bus.cpu_stall), 16'h0);
    chk("join_dma_gnt", 16'(bus.dma_gnt), 16'h0);
    chk("join_rvalid", 16'(bus.dma_rvalid), 16'h1);
    chk("join_rdata", 16'(bus.dma_rdata), 16'hA5);
    step();
    cpu(0, 0, 16'h0, 8'h0);
    dma(0, 0, 16'h0, 8'h0);
    #1;
    chk("join_cpu_rdata", 16'(bus.cpu_rdata), 16'h5A);
    chk("join_rvalid_off", 16'(bus.dma_rvalid), 16'h0);
    step();
    // sustained contention
    cpu(1, 0, 16'h0010, 8'h00);
    dma(1, 0, 16'h0020, 8'h00);
    #1;
`ifdef DMEM_ARB_FAIR_EN
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("starve_deny%0d", i), 16'(bus.dma_gnt), 16'h0);
      chk($sformatf("starve_stall%0d", i), 16'(bus.cpu_stall), 16'h0);
      step();
    end
    chk("starve_force_gnt", 16'(bus.dma_gnt), 16'h1);
    chk("starve_force_stall", 16'(bus.cpu_stall), 16'h1);
    chk("starve_force_addr", 16'(bus.mem_addr), 16'h020);
    step();
    chk("starve_after_gnt", 16'(bus.dma_gnt), 16'h0);
    chk("starve_after_stall", 16'(bus.cpu_stall), 16'h0);
    chk("starve_after_rvalid", 16'(bus.dma_rvalid), 16'h1);
    chk("starve_after_rdata", 16'(bus.dma_rdata), 16'h5A);
    step();
    chk("starve_clr_gnt", 16'(bus.dma_gnt), 16'h0);
`else
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("strict_deny%0d", i), 16'(bus.dma_gnt), 16'h0);
      chk($sformatf("strict_stall%0d", i), 16'(bus.cpu_stall), 16'h0);
      step();
    end
    chk("strict_cpu_rdata", 16'(bus.cpu_rdata), 16'hA5);
`endif
    cpu(0, 0, 16'h0, 8'h0);
    dma(0, 0, 16'h0, 8'h0);
    step();
    // out-of-range accesses
    cpu(1, 1, 16'h0300, 8'hFF);
    #1;
    chk("oor_wr_mem_we", 16'(bus.mem_we), 16'h0);
    chk("oor_wr_stall", 16'(bus.cpu_stall), 16'h0);
    step();
    cpu(1, 0, 16'h0300, 8'h00);
    #1;
    chk("oor_rd_stall", 16'(bus.cpu_stall), 16'h0);
    step();
    cpu(0, 0, 16'h0, 8'h0);
    dma(1, 0, 16'h0210, 8'h00);
    #1;
    chk("oor_cpu_rdata", 16'(bus.cpu_rdata), 16'h00);
    chk("oor_dma_gnt", 16'(bus.dma_gnt), 16'h1);
    step();
    dma(0, 0, 16'h0, 8'h0);
    #1;
    chk("oor_dma_rvalid", 16'(bus.dma_rvalid), 16'h1);
    chk("oor_dma_rdata", 16'(bus.dma_rdata), 16'h00);
    step();
    // reset while a DMA read is in flight
    dma(1, 0, 16'h0020, 8'h00);
    #1;
    chk("rst_pre_gnt", 16'(bus.dma_gnt), 16'h1);
    #2;
    rst_i = 1'b1;
    dma(0, 0, 16'h0, 8'h0);
    #1;
    chk_idle("rst_async");
    step();
    chk_idle("rst_held");
    rst_i = 1'b0;
    step();
    chk_idle("rst_after1");
    step();
    chk("rst_after2_rvalid", 16'(bus.dma_rvalid), 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
